// File: rtl/d_mem_resp.sv
// Data-memory responder: byte RAM plus an MMIO window holding a console TX FIFO,
// a GPIO output register and a 16-bit free-running timer with a latched high byte.
module d_mem_resp #(
  parameter logic [11:0] MMIO_BASE     = 12'hFF0,
  parameter int          RAM_DEPTH     = 4080,
  parameter int          TX_FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [11:0] d_mem_addr,
  input  logic [7:0]  d_mem_wr_data,
  output logic [7:0]  d_mem_rd_data,
  input  logic        d_mem_en,
  input  logic        d_mem_rd,
  input  logic        d_mem_wr,
  output logic [7:0]  con_tx_data,
  output logic        con_tx_vld,
  input  logic        con_tx_rdy,
  output logic [7:0]  gpio_out
);

  localparam int          RAM_AW  = $clog2(RAM_DEPTH);
  localparam int          PTR_W   = $clog2(TX_FIFO_DEPTH);
  localparam int          CNT_W   = PTR_W + 1;
  localparam logic [11:0] RAM_TOP = 12'(RAM_DEPTH);

  typedef enum logic [11:0] {
    REG_CON_TX     = 12'd0,
    REG_CON_STATUS = 12'd1,
    REG_GPIO       = 12'd2,
    REG_TIMER_LO   = 12'd3,
    REG_TIMER_HI   = 12'd4,
    REG_TIMER_CTRL = 12'd5
  } mmio_reg_e;

  logic              rd_en, wr_en, is_ram, is_mmio;
  logic [11:0]       mmio_off;
  logic [RAM_AW-1:0] ram_idx;

  assign rd_en    = d_mem_en & d_mem_rd;
  assign wr_en    = d_mem_en & d_mem_wr;
  assign is_ram   = d_mem_addr < RAM_TOP;
  assign is_mmio  = d_mem_addr >= MMIO_BASE;
  assign mmio_off = d_mem_addr - MMIO_BASE;
  assign ram_idx  = d_mem_addr[RAM_AW-1:0];

  // ---------------------------------------------------------------- RAM
  logic [7:0] ram [RAM_DEPTH];

  // NOTE: storage arrays carry no reset; a reset branch would turn them into
  // thousands of flops instead of a RAM macro, and stale data is harmless.
  always_ff @(posedge clk) begin
    if (wr_en && is_ram) ram[ram_idx] <= d_mem_wr_data;
  end

  // ---------------------------------------------------------------- console FIFO
  logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop, push_ok, ovf_set, ovf_clr, overflow;

  assign full    = count == CNT_W'(TX_FIFO_DEPTH);
  assign empty   = count == '0;
  assign push    = wr_en && is_mmio && mmio_off == REG_CON_TX;
  assign pop     = con_tx_vld && con_tx_rdy;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign ovf_clr = wr_en && is_mmio && mmio_off == REG_CON_STATUS && d_mem_wr_data[2];

  assign con_tx_vld  = !empty;
  assign con_tx_data = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= d_mem_wr_data;
  end

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- GPIO and timer
  logic [15:0] timer;
  logic [7:0]  timer_shadow;
  logic        timer_en, timer_clr, ctrl_wr;

  assign ctrl_wr   = wr_en && is_mmio && mmio_off == REG_TIMER_CTRL;
  assign timer_clr = ctrl_wr && d_mem_wr_data[1];

  always_ff @(posedge clk) begin
    if (!reset_) begin
      gpio_out     <= 8'h00;
      timer        <= 16'h0000;
      timer_shadow <= 8'h00;
      timer_en     <= 1'b1;
    end else begin
      if (wr_en && is_mmio && mmio_off == REG_GPIO) gpio_out <= d_mem_wr_data;
      if (ctrl_wr) timer_en <= d_mem_wr_data[0];
      if (timer_clr)     timer <= 16'h0000;
      else if (timer_en) timer <= timer + 16'd1;
      // Latch the high byte on a low-byte read so a later HI read is coherent.
      if (rd_en && is_mmio && mmio_off == REG_TIMER_LO) timer_shadow <= timer[15:8];
    end
  end

  // ---------------------------------------------------------------- read mux
  // NOTE: the default assignment up front keeps this block free of latches.
  always_comb begin
    d_mem_rd_data = 8'h00;
    if (rd_en) begin
      if (is_ram) begin
        d_mem_rd_data = ram[ram_idx];
      end else if (is_mmio) begin
        case (mmio_off)
          REG_CON_STATUS: d_mem_rd_data = {4'(count), 1'b0, overflow, full, empty};
          REG_GPIO:       d_mem_rd_data = gpio_out;
          REG_TIMER_LO:   d_mem_rd_data = timer[7:0];
          REG_TIMER_HI:   d_mem_rd_data = timer_shadow;
          REG_TIMER_CTRL: d_mem_rd_data = {7'b0, timer_en};
          default:        d_mem_rd_data = 8'h00;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_d_mem_resp.sv
// Bench for d_mem_resp: directed steps plus random traffic, checked against a
// queue/array model of the memory map, FIFO and timer.
module tb_d_mem_resp;

  localparam int          RAM_DEPTH = 4064;   // leaves an unmapped hole below MMIO
  localparam logic [11:0] MMIO_BASE = 12'hFF0;
  localparam int          DEPTH     = 8;

  logic        clk = 1'b0;
  logic        reset_;
  logic [11:0] d_mem_addr;
  logic [7:0]  d_mem_wr_data, d_mem_rd_data;
  logic        d_mem_en, d_mem_rd, d_mem_wr;
  logic [7:0]  con_tx_data;
  logic        con_tx_vld, con_tx_rdy;
  logic [7:0]  gpio_out;

  d_mem_resp #(.MMIO_BASE(MMIO_BASE), .RAM_DEPTH(RAM_DEPTH), .TX_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_(reset_), .d_mem_addr(d_mem_addr), .d_mem_wr_data(d_mem_wr_data),
    .d_mem_rd_data(d_mem_rd_data), .d_mem_en(d_mem_en), .d_mem_rd(d_mem_rd),
    .d_mem_wr(d_mem_wr), .con_tx_data(con_tx_data), .con_tx_vld(con_tx_vld),
    .con_tx_rdy(con_tx_rdy), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_ram [int];
  logic [7:0]  q [$];
  logic        m_ovf, m_ten;
  logic [7:0]  m_gpio, m_shadow;
  logic [15:0] m_timer;

  int n_checks = 0;
  int n_passed = 0;
  int n_failed = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [11:0] a);
    logic [11:0] off;
    off = a - MMIO_BASE;
    if (a < 12'(RAM_DEPTH)) return m_ram[int'(a)];
    if (a < MMIO_BASE) return 8'h00;
    case (off)
      12'd1:   return {4'(q.size()), 1'b0, m_ovf, q.size() == DEPTH, q.size() == 0};
      12'd2:   return m_gpio;
      12'd3:   return m_timer[7:0];
      12'd4:   return m_shadow;
      12'd5:   return {7'b0, m_ten};
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 0; m_ten = 1; m_gpio = 8'h00; m_shadow = 8'h00; m_timer = 16'h0000;
  endfunction

  // Apply one clock edge worth of behaviour, using the state from before the edge.
  function automatic void model_update(input logic en, input logic rd, input logic wr,
                                       input logic [11:0] a, input logic [7:0] wd,
                                       input logic rdy);
    logic        rdv, wrv, mm, pop, push, ovf_set;
    logic [11:0] off;
    logic [15:0] t_old;
    rdv = en && rd; wrv = en && wr;
    mm  = a >= MMIO_BASE; off = a - MMIO_BASE;
    pop     = q.size() != 0 && rdy;
    push    = wrv && mm && off == 12'd0;
    ovf_set = push && q.size() == DEPTH && !pop;
    t_old   = m_timer;
    if (rdv && mm && off == 12'd3) m_shadow = t_old[15:8];
    if (wrv && mm && off == 12'd5 && wd[1]) m_timer = 16'h0000;
    else if (m_ten) m_timer = t_old + 16'd1;
    if (wrv && mm && off == 12'd5) m_ten = wd[0];
    if (wrv && mm && off == 12'd2) m_gpio = wd;
    if (wrv && a < 12'(RAM_DEPTH)) m_ram[int'(a)] = wd;
    if (pop) void'(q.pop_front());
    if (push && !ovf_set) q.push_back(wd);
    if (ovf_set) m_ovf = 1;
    else if (wrv && mm && off == 12'd1 && wd[2]) m_ovf = 0;
  endfunction

  // One bus cycle: drive after the falling edge, check mid-cycle, model the rising edge.
  task automatic step(input logic en, input logic rd, input logic wr, input logic [11:0] a,
                      input logic [7:0] wd, input logic rdy, output logic [7:0] obs);
    logic [7:0] exp_rd;
    logic       known;
    d_mem_en = en; d_mem_rd = rd; d_mem_wr = wr;
    d_mem_addr = a; d_mem_wr_data = wd; con_tx_rdy = rdy;
    #1;
    obs = d_mem_rd_data;
    known  = 1;
    exp_rd = 8'h00;
    if (en && rd) begin
      if (a < 12'(RAM_DEPTH) && !m_ram.exists(int'(a))) known = 0;
      else exp_rd = model_read(a);
    end
    if (known) check("rd_data", 16'(obs), 16'(exp_rd));
    check("tx_vld",  16'(con_tx_vld),  16'(q.size() != 0));
    check("tx_data", 16'(con_tx_data), (q.size() != 0) ? 16'(q[0]) : 16'h0000);
    check("gpio",    16'(gpio_out),    16'(m_gpio));
    @(posedge clk);
    model_update(en, rd, wr, a, wd, rdy);
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [11:0] a, input logic [7:0] d, input logic rdy = 0);
    logic [7:0] o;
    step(1, 0, 1, a, d, rdy, o);
  endtask

  task automatic rd_byte(input logic [11:0] a, output logic [7:0] o, input logic rdy = 0);
    step(1, 1, 0, a, 8'h00, rdy, o);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic [7:0] o;
    for (int i = 0; i < n; i++) step(0, 0, 0, 12'h000, 8'h00, rdy, o);
  endtask

  task automatic do_reset(input logic rdy);
    d_mem_en = 0; d_mem_rd = 0; d_mem_wr = 0; con_tx_rdy = rdy;
    reset_ = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset_ = 1'b1;
  endtask

  initial begin
    logic [7:0]  o, lo, hi, f1, f2;
    logic [15:0] t_at_lo;
    logic [11:0] a;
    reset_ = 1'b0; d_mem_en = 0; d_mem_rd = 0; d_mem_wr = 0;
    d_mem_addr = '0; d_mem_wr_data = '0; con_tx_rdy = 0;
    @(negedge clk);
    do_reset(0);

    // Reset state
    rd_byte(MMIO_BASE + 12'd1, o);
    check("reset_status", 16'(o), 16'h0001);
    rd_byte(MMIO_BASE + 12'd5, o);
    check("reset_timer_en", 16'(o), 16'h0001);

    // Prefill the RAM regions used by random traffic
    for (int i = 0; i < 16; i++) begin
      wr_byte(12'(i), 8'($urandom));
      wr_byte(12'hFD0 + 12'(i), 8'($urandom));
    end

    // RAM write/read and disabled read
    wr_byte(12'h010, 8'hA5);
    rd_byte(12'h010, o);
    check("ram_a5", 16'(o), 16'h00A5);
    step(0, 1, 0, 12'h011, 8'h00, 0, o);
    check("rd_no_en", 16'(o), 16'h0000);

    // GPIO and ignored regions
    wr_byte(MMIO_BASE + 12'd2, 8'h3C);
    idle(1, 0);
    rd_byte(MMIO_BASE + 12'd2, o);
    check("gpio_rd", 16'(o), 16'h003C);
    wr_byte(MMIO_BASE + 12'd8, 8'hEE);
    wr_byte(12'(RAM_DEPTH), 8'hEE);
    wr_byte(MMIO_BASE - 12'd1, 8'hEE);
    rd_byte(MMIO_BASE + 12'd8, o);
    check("mmio_hole", 16'(o), 16'h0000);
    rd_byte(12'(RAM_DEPTH), o);
    check("unmapped_lo", 16'(o), 16'h0000);
    rd_byte(MMIO_BASE - 12'd1, o);
    check("unmapped_hi", 16'(o), 16'h0000);

    // Overflow: nine pushes with consumer stalled
    for (int i = 1; i <= 9; i++) wr_byte(MMIO_BASE, 8'(i));
    rd_byte(MMIO_BASE + 12'd1, o);
    check("status_full_ovf", 16'(o), 16'h0086);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 16'(con_tx_data), 16'(i));
      idle(1, 1);
    end
    rd_byte(MMIO_BASE + 12'd1, o);
    check("status_empty_ovf", 16'(o), 16'h0005);
    wr_byte(MMIO_BASE + 12'd1, 8'h04);
    rd_byte(MMIO_BASE + 12'd1, o);
    check("status_ovf_clr", 16'(o), 16'h0001);

    // Push while full with a simultaneous pop
    for (int i = 0; i < 8; i++) wr_byte(MMIO_BASE, 8'h10 + 8'(i));
    wr_byte(MMIO_BASE, 8'h55, 1);
    rd_byte(MMIO_BASE + 12'd1, o);
    check("status_full_pushpop", 16'(o), 16'h0082);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("last_is_55", 16'(con_tx_data), 16'h0055);
      idle(1, 1);
    end
    check("drained_vld", 16'(con_tx_vld), 16'h0000);

    // Timer snapshot, clear and freeze
    do_reset(0);
    idle(300, 0);
    t_at_lo = m_timer;
    rd_byte(MMIO_BASE + 12'd3, lo);
    rd_byte(MMIO_BASE + 12'd4, hi);
    check("timer_snap", {hi, lo}, t_at_lo);
    check("timer_snap_abs", {hi, lo}, 16'd300);
    wr_byte(MMIO_BASE + 12'd5, 8'h02);
    rd_byte(MMIO_BASE + 12'd3, o);
    check("timer_cleared", 16'(o), 16'h0000);
    wr_byte(MMIO_BASE + 12'd5, 8'h01);
    idle(20, 0);
    wr_byte(MMIO_BASE + 12'd5, 8'h00);
    rd_byte(MMIO_BASE + 12'd3, f1);
    idle(5, 0);
    rd_byte(MMIO_BASE + 12'd3, f2);
    check("timer_frozen", 16'(f2), 16'(f1));
    wr_byte(MMIO_BASE + 12'd5, 8'h01);

    // Reset with bytes queued
    wr_byte(MMIO_BASE + 12'd2, 8'h77);
    for (int i = 0; i < 3; i++) wr_byte(MMIO_BASE, 8'hC0 + 8'(i));
    do_reset(1);
    check("rst_vld", 16'(con_tx_vld), 16'h0000);
    check("rst_gpio", 16'(gpio_out), 16'h0000);
    rd_byte(MMIO_BASE + 12'd1, o);
    check("rst_status", 16'(o), 16'h0001);
    rd_byte(12'h010, o);
    check("ram_retained", 16'(o), 16'h00A5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 12'($urandom_range(0, 15));
        1:       a = 12'hFD0 + 12'($urandom_range(0, 15));
        2:       a = MMIO_BASE + 12'($urandom_range(0, 15));
        3:       a = MMIO_BASE;
        default: a = 12'(RAM_DEPTH) + 12'($urandom_range(0, 15));
      endcase
      step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) == 0), a, 8'($urandom),
           1'($urandom_range(0, 2) == 0), o);
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
